// File: rtl/regfile_bank.sv
// regfile_bank: NREGS x WIDTH register bank.
//   - one byte-strobed write port (we/waddr/wdata/wstrb)
//   - two independent read ports (A/B), 1-cycle latency, with write-to-read bypass
//   - clear engine (clr_req/clr_busy) that zeroes one register per cycle
//   - snap_out: flat view of all registers, reg i at [i*WIDTH +: WIDTH]
// Optional: define REGFILE_PARITY_EN to add per-register even parity.
//   This adds the input par_inj and the outputs perr_a/perr_b.
// Reset: asynchronous, active-high (rst).

// Read port: registers the selected word from the bank's next-state view.
// A write or clear landing on the same edge is therefore returned (bypass).
module regfile_bank_rdport #(
    parameter int WIDTH = 8,
    parameter int NREGS = 10,
    parameter int AW    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        re,
    input  logic [AW-1:0]               raddr,
    input  logic [NREGS-1:0][WIDTH-1:0] regs_nxt,
`ifdef REGFILE_PARITY_EN
    input  logic [NREGS-1:0]            par_nxt,
    output logic                        perr,
`endif
    output logic [WIDTH-1:0]            rdata,
    output logic                        rvalid
);
    logic             in_range;
    logic [WIDTH-1:0] sel;

    assign in_range = int'(raddr) < NREGS;

    // Out-of-range addresses read as zero.
    always_comb begin
        sel = '0;
        if (in_range) sel = regs_nxt[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) rdata <= sel;
        end
    end

`ifdef REGFILE_PARITY_EN
    logic sel_par;

    always_comb begin
        sel_par = 1'b0;
        if (in_range) sel_par = par_nxt[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) perr <= 1'b0;
        else     perr <= re && in_range && (sel_par != ^sel);
    end
`endif
endmodule

module regfile_bank #(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 10,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [WIDTH/8-1:0]       wstrb,
    input  logic                     re_a,
    input  logic [AW-1:0]            raddr_a,
    output logic [WIDTH-1:0]         rdata_a,
    output logic                     rvalid_a,
    input  logic                     re_b,
    input  logic [AW-1:0]            raddr_b,
    output logic [WIDTH-1:0]         rdata_b,
    output logic                     rvalid_b,
    input  logic                     clr_req,
    output logic                     clr_busy,
`ifdef REGFILE_PARITY_EN
    input  logic                     par_inj,
    output logic                     perr_a,
    output logic                     perr_b,
`endif
    output logic [WIDTH*NREGS-1:0]   snap_out
);
    localparam int NB = WIDTH / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                      state, state_d;
    logic [AW-1:0]               cnt, cnt_d;
    logic [NREGS-1:0][WIDTH-1:0] regs, regs_nxt;
    logic                        wr_acc;

    // Writes are dropped while clearing, when out of range, or with no strobes.
    assign wr_acc   = we && (|wstrb) && (int'(waddr) < NREGS) && (state == IDLE);
    assign clr_busy = (state == CLEAR);
    assign snap_out = regs;

    // Next state of the array; the read ports sample this to get bypass.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        regs_nxt = regs;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                regs_nxt[cnt] = '0;
                cnt_d         = cnt + AW'(1);
                if (int'(cnt) == NREGS - 1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
        if (wr_acc) begin
            for (int k = 0; k < NB; k++) begin
                if (wstrb[k]) regs_nxt[waddr][8*k +: 8] = wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            regs  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            regs  <= regs_nxt;
        end
    end

`ifdef REGFILE_PARITY_EN
    logic [NREGS-1:0] par, par_nxt;

    // Parity is even over the merged word; par_inj flips it for error injection.
    always_comb begin
        par_nxt = par;
        if (state == CLEAR) par_nxt[cnt] = 1'b0;
        if (wr_acc) par_nxt[waddr] = (^regs_nxt[waddr]) ^ par_inj;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) par <= '0;
        else     par <= par_nxt;
    end
`endif

    // Both read ports are identical; pack them so one generate loop builds them.
    logic [1:0]            rp_re, rp_rvalid;
    logic [1:0][AW-1:0]    rp_raddr;
    logic [1:0][WIDTH-1:0] rp_rdata;
`ifdef REGFILE_PARITY_EN
    logic [1:0]            rp_perr;
    assign perr_a = rp_perr[0];
    assign perr_b = rp_perr[1];
`endif

    assign rp_re    = {re_b, re_a};
    assign rp_raddr = {raddr_b, raddr_a};
    assign rdata_a  = rp_rdata[0];
    assign rdata_b  = rp_rdata[1];
    assign rvalid_a = rp_rvalid[0];
    assign rvalid_b = rp_rvalid[1];

    for (genvar p = 0; p < 2; p++) begin : g_rd
        regfile_bank_rdport #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_rd (
            .clk      (clk),
            .rst      (rst),
            .re       (rp_re[p]),
            .raddr    (rp_raddr[p]),
            .regs_nxt (regs_nxt),
`ifdef REGFILE_PARITY_EN
            .par_nxt  (par_nxt),
            .perr     (rp_perr[p]),
`endif
            .rdata    (rp_rdata[p]),
            .rvalid   (rp_rvalid[p])
        );
    end
endmodule

// File: tb/tb_regfile_bank.sv
`timescale 1ns/1ps
module tb_regfile_bank;
    localparam int WIDTH = 16;
    localparam int NREGS = 10;
    localparam int AW    = $clog2(NREGS);
    localparam int NB    = WIDTH / 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   we = 1'b0;
    logic [AW-1:0]          waddr = '0;
    logic [WIDTH-1:0]       wdata = '0;
    logic [NB-1:0]          wstrb = '0;
    logic                   re_a = 1'b0, re_b = 1'b0;
    logic [AW-1:0]          raddr_a = '0, raddr_b = '0;
    logic [WIDTH-1:0]       rdata_a, rdata_b;
    logic                   rvalid_a, rvalid_b;
    logic                   clr_req = 1'b0;
    logic                   clr_busy;
    logic [WIDTH*NREGS-1:0] snap_out;
`ifdef REGFILE_PARITY_EN
    logic                   par_inj = 1'b0;
    logic                   perr_a, perr_b;
`endif

    regfile_bank #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
        .clr_req(clr_req), .clr_busy(clr_busy),
`ifdef REGFILE_PARITY_EN
        .par_inj(par_inj), .perr_a(perr_a), .perr_b(perr_b),
`endif
        .snap_out(snap_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: plain array of words plus a "next register to clear" index.
    logic [WIDTH-1:0] m  [NREGS];
    logic             mp [NREGS];
    int               clr_idx = -1;
    logic [WIDTH-1:0] e_rd_a, e_rd_b;
    logic             e_rv_a, e_rv_b, e_pe_a, e_pe_b;

    function automatic logic [WIDTH*NREGS-1:0] model_snap();
        logic [WIDTH*NREGS-1:0] s;
        for (int i = 0; i < NREGS; i++) s[i*WIDTH +: WIDTH] = m[i];
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m[i]  = '0;
            mp[i] = 1'b0;
        end
        clr_idx = -1;
        e_rd_a = '0; e_rd_b = '0;
        e_rv_a = 1'b0; e_rv_b = 1'b0; e_pe_a = 1'b0; e_pe_b = 1'b0;
    endtask

    // Apply the effect of one clock edge with the current inputs.
    task automatic model_edge();
        logic [WIDTH-1:0] v;
        logic inj;
        inj = 1'b0;
`ifdef REGFILE_PARITY_EN
        inj = par_inj;
`endif
        if (clr_idx >= 0) begin
            m[clr_idx]  = '0;
            mp[clr_idx] = 1'b0;
            clr_idx++;
            if (clr_idx == NREGS) clr_idx = -1;
        end else begin
            if (we && wstrb != '0 && int'(waddr) < NREGS) begin
                v = m[waddr];
                for (int k = 0; k < NB; k++)
                    if (wstrb[k]) v[8*k +: 8] = wdata[8*k +: 8];
                m[waddr]  = v;
                mp[waddr] = (^v) ^ inj;
            end
            if (clr_req) clr_idx = 0;
        end
        e_rv_a = re_a;
        e_pe_a = 1'b0;
        if (re_a) begin
            if (int'(raddr_a) < NREGS) begin
                e_rd_a = m[raddr_a];
                e_pe_a = mp[raddr_a] != ^m[raddr_a];
            end else e_rd_a = '0;
        end
        e_rv_b = re_b;
        e_pe_b = 1'b0;
        if (re_b) begin
            if (int'(raddr_b) < NREGS) begin
                e_rd_b = m[raddr_b];
                e_pe_b = mp[raddr_b] != ^m[raddr_b];
            end else e_rd_b = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
        re_a = 1'b0; re_b = 1'b0; raddr_a = '0; raddr_b = '0;
        clr_req = 1'b0;
`ifdef REGFILE_PARITY_EN
        par_inj = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (clr_busy !== 1'b0 || rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b rvalid_a=%b rvalid_b=%b, want all 0", clr_busy, rvalid_a, rvalid_b);
        end
        checks++;
        if (rdata_a !== '0 || rdata_b !== '0) begin
            errors++;
            $display("FAIL reset_rdata: a=%h b=%h, want 0", rdata_a, rdata_b);
        end
        checks++;
        if (snap_out !== '0) begin
            errors++;
            $display("FAIL reset_snap: got %h, want 0", snap_out);
        end
        rst = 1'b0;
        for (int a = 0; a <= NREGS; a++) begin
            re_a = 1'b1; raddr_a = AW'(a);
            re_b = 1'b1; raddr_b = AW'(NREGS - a);
            step();
            checks++;
            if (rdata_a !== '0 || rvalid_a !== 1'b1) begin
                errors++;
                $display("FAIL reset_read_a[%0d]: rdata=%h rvalid=%b, want 0/1", a, rdata_a, rvalid_a);
            end
            checks++;
            if (rdata_b !== '0 || rvalid_b !== 1'b1) begin
                errors++;
                $display("FAIL reset_read_b[%0d]: rdata=%h rvalid=%b, want 0/1", a, rdata_b, rvalid_b);
            end
        end
        idle();
        step();
        checks++;
        if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_drop: a=%b b=%b, want 0", rvalid_a, rvalid_b);
        end
    endtask

    task automatic test_strobe();
        we = 1'b1; waddr = 3; wdata = 16'hABCD; wstrb = 2'b11;
        step();
        wdata = 16'h1234; wstrb = 2'b01;
        step();
        idle();
        re_a = 1'b1; raddr_a = 3;
        step();
        checks++;
        if (rdata_a !== 16'hAB34 || rvalid_a !== 1'b1) begin
            errors++;
            $display("FAIL strobe_read: rdata=%h rvalid=%b, want ab34/1", rdata_a, rvalid_a);
        end
        checks++;
        if (snap_out[63:48] !== 16'hAB34) begin
            errors++;
            $display("FAIL strobe_snap: got %h, want ab34", snap_out[63:48]);
        end
        idle();
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 4; wdata = 16'h0077; wstrb = 2'b11;
        step();
        waddr = 5; wdata = 16'h005A;
        re_a = 1'b1; raddr_a = 5;
        re_b = 1'b1; raddr_b = 4;
        step();
        checks++;
        if (rdata_a !== 16'h005A || rvalid_a !== 1'b1) begin
            errors++;
            $display("FAIL bypass_a: rdata=%h rvalid=%b, want 005a/1", rdata_a, rvalid_a);
        end
        checks++;
        if (rdata_b !== 16'h0077 || rvalid_b !== 1'b1) begin
            errors++;
            $display("FAIL bypass_b: rdata=%h rvalid=%b, want 0077/1", rdata_b, rvalid_b);
        end
        idle();
        step();
        checks++;
        if (rdata_a !== 16'h005A || rvalid_a !== 1'b0) begin
            errors++;
            $display("FAIL read_hold: rdata=%h rvalid=%b, want 005a/0", rdata_a, rvalid_a);
        end
    endtask

    task automatic test_oob();
        we = 1'b1; waddr = 7; wdata = 16'hC3C3; wstrb = 2'b11;
        step();
        we = 1'b0;
        re_a = 1'b1; raddr_a = 7; re_b = 1'b1; raddr_b = 7;
        step();
        we = 1'b1; waddr = AW'(NREGS); wdata = 16'hFFFF; wstrb = 2'b11;
        re_a = 1'b1; raddr_a = AW'(NREGS);
        re_b = 1'b1; raddr_b = '1;
        step();
        checks++;
        if (snap_out !== model_snap()) begin
            errors++;
            $display("FAIL oob_write: snap=%h, want %h", snap_out, model_snap());
        end
        checks++;
        if (rdata_a !== '0 || rvalid_a !== 1'b1 || rdata_b !== '0 || rvalid_b !== 1'b1) begin
            errors++;
            $display("FAIL oob_read: a=%h/%b b=%h/%b, want 0/1", rdata_a, rvalid_a, rdata_b, rvalid_b);
        end
        idle();
        we = 1'b1; waddr = 7; wdata = 16'h0000; wstrb = '0;
        step();
        checks++;
        if (snap_out[7*WIDTH +: WIDTH] !== 16'hC3C3) begin
            errors++;
            $display("FAIL zero_strobe: reg7=%h, want c3c3", snap_out[7*WIDTH +: WIDTH]);
        end
        idle();
    endtask

`ifdef REGFILE_PARITY_EN
    task automatic test_parity();
        we = 1'b1; waddr = 1; wdata = 16'h000F; wstrb = 2'b11; par_inj = 1'b1;
        step();
        idle();
        re_a = 1'b1; raddr_a = 1;
        re_b = 1'b1; raddr_b = AW'(NREGS);
        step();
        checks++;
        if (perr_a !== 1'b1 || rvalid_a !== 1'b1) begin
            errors++;
            $display("FAIL parity_inj: perr_a=%b rvalid_a=%b, want 1/1", perr_a, rvalid_a);
        end
        checks++;
        if (perr_b !== 1'b0) begin
            errors++;
            $display("FAIL parity_oob: perr_b=%b, want 0", perr_b);
        end
        idle();
        we = 1'b1; waddr = 1; wdata = 16'h000F; wstrb = 2'b11;
        step();
        idle();
        re_a = 1'b1; raddr_a = 1;
        step();
        checks++;
        if (perr_a !== 1'b0 || rvalid_a !== 1'b1) begin
            errors++;
            $display("FAIL parity_clean: perr_a=%b rvalid_a=%b, want 0/1", perr_a, rvalid_a);
        end
        idle();
    endtask
`endif

    task automatic test_clear();
        int c;
        for (int i = 0; i < NREGS; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = WIDTH'($urandom | 1); wstrb = '1;
            step();
        end
        idle();
        clr_req = 1'b1;
        step();
        checks++;
        if (clr_busy !== 1'b1) begin
            errors++;
            $display("FAIL clr_start: busy=%b, want 1", clr_busy);
        end
        c = 0;
        while (clr_busy === 1'b1 && c < 3 * NREGS) begin
            clr_req = (c < 3);
            we = (c == 1); waddr = 2; wdata = 16'hFFFF; wstrb = '1;
            re_a = 1'b1; raddr_a = AW'(c);
            re_b = 1'b1; raddr_b = AW'((c + 1) % NREGS);
            step();
            c++;
            checks++;
            if (rdata_a !== '0) begin
                errors++;
                $display("FAIL clr_bypass[%0d]: rdata_a=%h, want 0", c, rdata_a);
            end
            checks++;
            if (rdata_b !== e_rd_b) begin
                errors++;
                $display("FAIL clr_read_b[%0d]: rdata_b=%h, want %h", c, rdata_b, e_rd_b);
            end
        end
        idle();
        checks++;
        if (c != NREGS) begin
            errors++;
            $display("FAIL clr_len: busy cycles=%0d, want %0d", c + 1 - 1, NREGS);
        end
        checks++;
        if (snap_out !== '0) begin
            errors++;
            $display("FAIL clr_result: snap=%h, want 0", snap_out);
        end
        step();
        checks++;
        if (clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_restart: busy=%b, want 0", clr_busy);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            we      = 1'($urandom_range(0, 1));
            waddr   = AW'($urandom_range(0, NREGS + 2));
            wdata   = WIDTH'($urandom);
            wstrb   = NB'($urandom);
            re_a    = 1'($urandom_range(0, 1));
            raddr_a = AW'($urandom_range(0, NREGS + 1));
            re_b    = 1'($urandom_range(0, 1));
            raddr_b = AW'($urandom_range(0, NREGS + 1));
            clr_req = ($urandom_range(0, 40) == 0);
`ifdef REGFILE_PARITY_EN
            par_inj = ($urandom_range(0, 7) == 0);
`endif
            step();
            checks++;
            if (rvalid_a !== e_rv_a || rdata_a !== e_rd_a) begin
                errors++;
                $display("FAIL rand_a[%0d]: %h/%b, want %h/%b", n, rdata_a, rvalid_a, e_rd_a, e_rv_a);
            end
            checks++;
            if (rvalid_b !== e_rv_b || rdata_b !== e_rd_b) begin
                errors++;
                $display("FAIL rand_b[%0d]: %h/%b, want %h/%b", n, rdata_b, rvalid_b, e_rd_b, e_rv_b);
            end
            checks++;
            if (clr_busy !== (clr_idx >= 0)) begin
                errors++;
                $display("FAIL rand_busy[%0d]: %b, want %b", n, clr_busy, clr_idx >= 0);
            end
            checks++;
            if (snap_out !== model_snap()) begin
                errors++;
                $display("FAIL rand_snap[%0d]: %h, want %h", n, snap_out, model_snap());
            end
`ifdef REGFILE_PARITY_EN
            checks++;
            if (perr_a !== e_pe_a || perr_b !== e_pe_b) begin
                errors++;
                $display("FAIL rand_perr[%0d]: %b%b, want %b%b", n, perr_a, perr_b, e_pe_a, e_pe_b);
            end
`endif
        end
        idle();
    endtask

    task automatic test_reset_midclear();
        for (int i = 0; i < NREGS; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = 16'h8001; wstrb = '1;
            step();
        end
        idle();
        clr_req = 1'b1;
        step();
        idle();
        step();
        re_a = 1'b1; raddr_a = 8;
        step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (clr_busy !== 1'b0 || rvalid_a !== 1'b0 || rdata_a !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b rvalid_a=%b rdata_a=%h, want 0", clr_busy, rvalid_a, rdata_a);
        end
        checks++;
        if (snap_out !== '0) begin
            errors++;
            $display("FAIL async_reset_snap: %h, want 0", snap_out);
        end
        idle();
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_busy: %b, want 0", clr_busy);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_strobe();
        test_bypass();
        test_oob();
`ifdef REGFILE_PARITY_EN
        test_parity();
`endif
        test_clear();
        test_random();
        test_reset_midclear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
Parametrised successor to the flat register bank. Provides an NREGS x WIDTH register array with:
- one byte-strobed write port
- two independent registered read ports with write-to-read bypass
- a sequenced clear engine
- a flat snapshot output of all registers

Used as a general-purpose configuration and scratch store next to datapath blocks.

Parameters:
WIDTH, 8, bits per register; must be a multiple of 8.
NREGS, 10, number of registers; must be >= 2.
AW, $clog2(NREGS), address width (localparam, derived; not overridable).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
we  input  1  write enable.
waddr  input  AW  write address.
wdata  input  WIDTH  write data.
wstrb  input  WIDTH/8  byte strobes; bit k enables wdata[8k+7:8k].
re_a  input  1  read request, port A.
raddr_a  input  AW  read address, port A.
rdata_a  output  WIDTH  read data, port A.
rvalid_a  output  1  read data valid, port A.
re_b, raddr_b, rdata_b, rvalid_b  as port A, port B.
clr_req  input  1  start a clear of all registers.
clr_busy  output  1  clear sequence in progress.
snap_out  output  WIDTH*NREGS  all registers; reg i at [i*WIDTH +: WIDTH].

Behaviour:
- Reset (rst high, asynchronous): all registers 0; rdata_a/b 0; rvalid_a/b 0; clr_busy 0; clear counter 0; FSM IDLE.
- Write: when we=1, waddr<NREGS and clr_busy=0, only the strobed bytes of reg[waddr] update at the edge; other bytes hold.
  - Dropped writes: waddr>=NREGS, or clr_busy=1. No state changes.
  - we=1 with wstrb=0 is a no-op.
- Read latency is 1 cycle. rvalid_x(t+1) = re_x(t).
  - rdata_x(t+1) = reg[raddr_x] as it stands after edge t; a same-cycle write to that address returns the merged new value (bypass).
  - raddr_x>=NREGS returns 0, with rvalid still asserted.
  - When re_x=0, rdata_x holds its previous value.
- Ports A and B are fully independent and may read the same address.
- Clear FSM, 2 states:
  - IDLE: clr_req=1 -> CLEAR; counter=0; clr_busy=1 from the next cycle.
  - CLEAR: each cycle reg[counter] <= 0 and counter increments. When counter==NREGS-1 that register clears -> IDLE; clr_busy=0 the following cycle.
  - Total clr_busy high time is exactly NREGS cycles.
  - clr_req during CLEAR is ignored (no restart).
  - Reads during CLEAR are served. Reading the register cleared in the same cycle returns 0 (bypass).
- snap_out is driven directly from the register array and reflects each edge's update with no extra latency.
- Reset asserted mid-clear or mid-read aborts immediately to the reset values.

Optional Feature:
Macro: REGFILE_PARITY_EN.
- Defined:
  - Each register stores an extra even-parity bit, computed over the merged post-write value; cleared registers store parity 0.
  - New input par_inj (1): when high with an accepted write, the stored parity bit is inverted.
  - New outputs perr_a/perr_b (1): asserted alongside rvalid_x when the stored parity of the read register mismatches the recomputed parity. perr_x is 0 for out-of-range reads. Reset value 0.
  - Parity bits are not included in snap_out.
- Not defined: par_inj, perr_a and perr_b do not exist; no parity storage.

Test Plan:
1. Reset, then read all addresses on both ports -> rdata 0, rvalid high 1 cycle after each re; snap_out all 0.
2. WIDTH=16: write reg3=0xABCD with wstrb=11, then 0x1234 with wstrb=01 -> read returns 0xAB34; snap_out[63:48]=0xAB34.
3. Write reg5=0x5A while re_a on addr 5 in the same cycle -> rdata_a=0x5A next cycle (bypass); port B on addr 4 returns its old value.
4. Fill all regs, pulse clr_req, issue a write to reg2 during CLEAR -> clr_busy high exactly NREGS cycles; all regs 0 after; write dropped.
5. waddr=NREGS with we=1 -> no change in snap_out; read raddr=NREGS -> 0 with rvalid=1.
6. (REGFILE_PARITY_EN) write reg1=0x0F with par_inj=1, read port A -> perr_a=1 with rvalid_a; normal rewrite, read again -> perr_a=0.
